// File: rtl/memory_arbiter_pkg.sv
// Shared types and default widths for the unified-RAM arbiter and its RAM model.
package memory_arbiter_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    // Encoding 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        FETCH_WAIT = 2'b01,
        DATA_WAIT  = 2'b10,
        BAD_STATE  = 2'b11
    } arb_state_e;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of pipeline-side and RAM-side signals around the arbiter.
// master = the arbiter itself, slave = pipeline stages plus RAM.
interface memory_arbiter_if
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    // Fetch stage
    logic              ifReq;
    logic [ADDR_W-1:0] ifAddr;
    logic              ifFlush;
    logic [DATA_W-1:0] ifData;
    logic              ifValid;
    // Memory stage
    logic              exMemMemRead;
    logic              exMemMemWrite;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWData;
    logic [DATA_W-1:0] memRData;
    logic              memValid;
    // RAM port
    logic              ramEn;
    logic              ramWe;
    logic [ADDR_W-1:0] ramAddr;
    logic [DATA_W-1:0] ramWData;
    logic [DATA_W-1:0] ramRData;
    logic              ramReady;
    // Pipeline freeze
    logic              pcWrite;
    logic              ifIdWrite;
    logic              memStall;

    modport master (
        input  ifReq, ifAddr, ifFlush,
        input  exMemMemRead, exMemMemWrite, memAddr, memWData,
        input  ramRData, ramReady,
        output ifData, ifValid, memRData, memValid,
        output ramEn, ramWe, ramAddr, ramWData,
        output pcWrite, ifIdWrite, memStall
    );

    modport slave (
        output ifReq, ifAddr, ifFlush,
        output exMemMemRead, exMemMemWrite, memAddr, memWData,
        output ramRData, ramReady,
        input  ifData, ifValid, memRData, memValid,
        input  ramEn, ramWe, ramAddr, ramWData,
        input  pcWrite, ifIdWrite, memStall
    );

endinterface

// File: rtl/memory_arbiter.sv
// Arbitrates the single-ported unified RAM between instruction fetch and the
// MEM stage (data first), sequences each access through the ramReady
// handshake and produces the pipeline freeze signals.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input logic                clk,
    input logic                resetN,
    memory_arbiter_if.master   bus
);

    arb_state_e        r_state,     w_state_nxt;
    logic              r_ram_en,    w_ram_en_nxt;
    logic              r_ram_we,    w_ram_we_nxt;
    logic [ADDR_W-1:0] r_ram_addr,  w_ram_addr_nxt;
    logic [DATA_W-1:0] r_ram_wdata, w_ram_wdata_nxt;
    logic [DATA_W-1:0] r_if_data,   w_if_data_nxt;
    logic [DATA_W-1:0] r_mem_rdata, w_mem_rdata_nxt;
    logic              r_if_valid,  w_if_valid_nxt;
    logic              r_mem_valid, w_mem_valid_nxt;
    logic              r_discard,   w_discard_nxt;

    logic              w_data_req;
    logic              w_fetch_req;
    logic              w_discard_now;
    logic              w_mem_stall;

    // A request whose valid is high this cycle has already been served;
    // the request line only still shows it because the pipeline advances now.
    assign w_data_req    = (bus.exMemMemRead | bus.exMemMemWrite) & ~r_mem_valid;
    assign w_fetch_req   = bus.ifReq & ~r_if_valid;
    assign w_discard_now = r_discard | bus.ifFlush;

    // Next-state and next-output logic for the arbiter FSM.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        w_state_nxt     = r_state;
        w_ram_en_nxt    = r_ram_en;
        w_ram_we_nxt    = r_ram_we;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_wdata_nxt = r_ram_wdata;
        w_if_data_nxt   = r_if_data;
        w_mem_rdata_nxt = r_mem_rdata;
        w_if_valid_nxt  = 1'b0;
        w_mem_valid_nxt = 1'b0;
        w_discard_nxt   = r_discard;

        case (r_state)
            IDLE: begin
                w_discard_nxt = 1'b0;
                if (w_data_req) begin
                    // Store wins when load and store are both (illegally) set.
                    w_ram_en_nxt    = 1'b1;
                    w_ram_we_nxt    = bus.exMemMemWrite;
                    w_ram_addr_nxt  = bus.memAddr;
                    w_ram_wdata_nxt = bus.memWData;
                    w_state_nxt     = DATA_WAIT;
                end else if (w_fetch_req) begin
                    w_ram_en_nxt   = 1'b1;
                    w_ram_we_nxt   = 1'b0;
                    w_ram_addr_nxt = bus.ifAddr;
                    w_state_nxt    = FETCH_WAIT;
                end
            end

            FETCH_WAIT: begin
                w_discard_nxt = w_discard_now;
                if (bus.ramReady) begin
                    w_ram_en_nxt  = 1'b0;
                    w_ram_we_nxt  = 1'b0;
                    w_discard_nxt = 1'b0;
                    w_state_nxt   = IDLE;
                    // A flushed fetch still finishes on the RAM side but is dropped here.
                    if (!w_discard_now) begin
                        w_if_data_nxt  = bus.ramRData;
                        w_if_valid_nxt = 1'b1;
                    end
                end
            end

            DATA_WAIT: begin
                if (bus.ramReady) begin
                    w_ram_en_nxt    = 1'b0;
                    w_ram_we_nxt    = 1'b0;
                    w_mem_valid_nxt = 1'b1;
                    w_state_nxt     = IDLE;
                    // Only loads return data; a store leaves the last load result intact.
                    if (!r_ram_we) begin
                        w_mem_rdata_nxt = bus.ramRData;
                    end
                end
            end

            default: begin
                w_ram_en_nxt  = 1'b0;
                w_ram_we_nxt  = 1'b0;
                w_discard_nxt = 1'b0;
                w_state_nxt   = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_state     <= IDLE;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_if_data   <= '0;
            r_mem_rdata <= '0;
            r_if_valid  <= 1'b0;
            r_mem_valid <= 1'b0;
            r_discard   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ram_en    <= w_ram_en_nxt;
            r_ram_we    <= w_ram_we_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_wdata <= w_ram_wdata_nxt;
            r_if_data   <= w_if_data_nxt;
            r_mem_rdata <= w_mem_rdata_nxt;
            r_if_valid  <= w_if_valid_nxt;
            r_mem_valid <= w_mem_valid_nxt;
            r_discard   <= w_discard_nxt;
        end
    end

    // Freeze signals: hold everything while a data access is pending, and
    // hold PC / IF-ID while an instruction has not yet arrived.
    assign w_mem_stall   = (bus.exMemMemRead | bus.exMemMemWrite) & ~r_mem_valid;
    assign bus.memStall  = w_mem_stall;
    assign bus.pcWrite   = ~w_mem_stall & ~(bus.ifReq & ~r_if_valid);
    assign bus.ifIdWrite = ~w_mem_stall & ~(bus.ifReq & ~r_if_valid);

    assign bus.ramEn    = r_ram_en;
    assign bus.ramWe    = r_ram_we;
    assign bus.ramAddr  = r_ram_addr;
    assign bus.ramWData = r_ram_wdata;
    assign bus.ifData   = r_if_data;
    assign bus.ifValid  = r_if_valid;
    assign bus.memRData = r_mem_rdata;
    assign bus.memValid = r_mem_valid;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: fetch, priority, waited store, flush and
// mid-transaction reset, each against hand-computed cycle-by-cycle values.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    logic clk;
    logic resetN;
    int   n_tests;
    int   n_fail;

    memory_arbiter_if #(.ADDR_W(DEF_ADDR_W), .DATA_W(DEF_DATA_W)) bus ();

    memory_arbiter #(.ADDR_W(DEF_ADDR_W), .DATA_W(DEF_DATA_W)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Move to just after the next rising edge; inputs are then driven and
    // outputs sampled one time unit later, well clear of the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        resetN            = 1'b0;
        bus.ifReq         = 1'b0;
        bus.ifAddr        = '0;
        bus.ifFlush       = 1'b0;
        bus.exMemMemRead  = 1'b0;
        bus.exMemMemWrite = 1'b0;
        bus.memAddr       = '0;
        bus.memWData      = '0;
        bus.ramRData      = '0;
        bus.ramReady      = 1'b1;

        // ---- reset state ----
        tick(); tick();
        settle();
        check("rst_en_we",    32'({bus.ramEn, bus.ramWe, bus.ifValid, bus.memValid}), 32'h0);
        check("rst_addr_wd",  32'({bus.ramAddr, bus.ramWData}), 32'h0);
        check("rst_data",     32'({bus.ifData, bus.memRData}), 32'h0);
        check("rst_stall",    32'({bus.memStall, bus.pcWrite, bus.ifIdWrite}), 32'b011);
        resetN = 1'b1;

        // ---- single fetch, zero wait ----
        tick();                                   // cycle 0
        bus.ifReq = 1'b1; bus.ifAddr = 16'h0004; bus.ramReady = 1'b1;
        settle();
        check("f_c0_pcw",     32'({bus.pcWrite, bus.ifIdWrite, bus.ramEn}), 32'b000);
        tick();                                   // cycle 1
        check("f_c1_ram",     32'({bus.ramEn, bus.ramWe, bus.ramAddr}), {14'd0, 2'b10, 16'h0004});
        check("f_c1_pcw",     32'({bus.pcWrite, bus.ifValid}), 32'b00);
        bus.ramRData = 16'h1234;
        tick();                                   // cycle 2
        check("f_c2_valid",   32'({bus.ifValid, bus.ifData}), {15'd0, 1'b1, 16'h1234});
        check("f_c2_pcw",     32'({bus.pcWrite, bus.ifIdWrite, bus.ramEn}), 32'b110);
        tick();                                   // cycle 3: held request was ignored
        check("f_c3_ignored", 32'({bus.ramEn, bus.ifValid}), 32'b00);
        bus.ifReq = 1'b0;

        // ---- simultaneous fetch + load ----
        tick();                                   // cycle 0
        bus.ifReq = 1'b1; bus.ifAddr = 16'h0008;
        bus.exMemMemRead = 1'b1; bus.memAddr = 16'h0100;
        settle();
        check("s_c0_stall",   32'({bus.memStall, bus.pcWrite}), 32'b10);
        tick();                                   // cycle 1
        check("s_c1_ram",     32'({bus.ramEn, bus.ramWe, bus.ramAddr}), {14'd0, 2'b10, 16'h0100});
        check("s_c1_stall",   32'(bus.memStall), 32'h1);
        bus.ramRData = 16'hCAFE;
        tick();                                   // cycle 2
        check("s_c2_mvalid",  32'({bus.memValid, bus.memRData}), {15'd0, 1'b1, 16'hCAFE});
        check("s_c2_stall",   32'({bus.memStall, bus.pcWrite, bus.ifValid}), 32'b000);
        tick();                                   // cycle 3
        bus.exMemMemRead = 1'b0;
        settle();
        check("s_c3_fetch",   32'({bus.ramEn, bus.ramWe, bus.ramAddr}), {14'd0, 2'b10, 16'h0008});
        check("s_c3_mvalid",  32'(bus.memValid), 32'h0);
        bus.ramRData = 16'h5555;
        tick();                                   // cycle 4
        check("s_c4_ivalid",  32'({bus.ifValid, bus.ifData}), {15'd0, 1'b1, 16'h5555});
        check("s_c4_mrdata",  32'(bus.memRData), 32'hCAFE);
        tick();
        bus.ifReq = 1'b0;

        // ---- store with 3 wait states ----
        tick();                                   // cycle 0
        bus.exMemMemWrite = 1'b1; bus.memAddr = 16'h0200; bus.memWData = 16'hBEEF;
        bus.ramReady = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();                               // cycles 1..4
            check($sformatf("w_c%0d_ram", c), 32'({bus.ramEn, bus.ramWe, bus.memValid}), 32'b110);
            check($sformatf("w_c%0d_ad", c),  32'({bus.ramAddr, bus.ramWData}), {16'h0200, 16'hBEEF});
            if (c == 2) begin
                bus.memAddr = 16'hFFFF; bus.memWData = 16'h0000;
            end
            if (c == 4) begin
                bus.ramReady = 1'b1; bus.ramRData = 16'h1111;
            end
        end
        tick();                                   // cycle 5
        check("w_c5_valid",   32'({bus.memValid, bus.ramEn, bus.ramWe}), 32'b100);
        check("w_c5_rdata",   32'(bus.memRData), 32'hCAFE);
        bus.exMemMemWrite = 1'b0; bus.ramReady = 1'b0;

        // ---- flush during fetch ----
        tick();                                   // cycle 0
        bus.ifReq = 1'b1; bus.ifAddr = 16'h0010;
        tick();                                   // cycle 1
        check("fl_c1_ram",    32'({bus.ramEn, bus.ramAddr}), {15'd0, 1'b1, 16'h0010});
        bus.ifFlush = 1'b1;
        tick();                                   // cycle 2
        bus.ifFlush = 1'b0; bus.ifAddr = 16'h0040;
        bus.ramReady = 1'b1; bus.ramRData = 16'hDEAD;
        tick();                                   // cycle 3
        check("fl_c3_novalid", 32'({bus.ifValid, bus.ramEn}), 32'b00);
        check("fl_c3_data",    32'(bus.ifData), 32'h5555);
        tick();                                   // cycle 4: refetch issued
        check("fl_c4_ram",    32'({bus.ramEn, bus.ramAddr}), {15'd0, 1'b1, 16'h0040});
        bus.ramRData = 16'h7777;
        tick();                                   // cycle 5
        check("fl_c5_valid",  32'({bus.ifValid, bus.ifData}), {15'd0, 1'b1, 16'h7777});
        bus.ifReq = 1'b0; bus.ramReady = 1'b0;

        // ---- reset during DATA_WAIT ----
        tick();                                   // cycle 0
        bus.exMemMemRead = 1'b1; bus.memAddr = 16'h0300;
        tick();                                   // cycle 1
        check("r_c1_ram",     32'({bus.ramEn, bus.ramAddr}), {15'd0, 1'b1, 16'h0300});
        resetN = 1'b0;
        tick();                                   // cycle 2: reset applied
        check("r_c2_ctl",     32'({bus.ramEn, bus.ramWe, bus.ifValid, bus.memValid}), 32'h0);
        check("r_c2_data",    32'({bus.ifData, bus.memRData}), 32'h0);
        check("r_c2_addr",    32'({bus.ramAddr, bus.ramWData}), 32'h0);
        resetN = 1'b1; bus.exMemMemRead = 1'b0;
        bus.ramReady = 1'b1; bus.ramRData = 16'h9999;
        tick();                                   // cycle 3
        check("r_c3_quiet",   32'({bus.memValid, bus.ramEn, bus.memRData}), 32'h0);
        bus.exMemMemRead = 1'b1; bus.memAddr = 16'h0304;
        tick();                                   // new request in flight
        check("r_c4_ram",     32'({bus.ramEn, bus.ramAddr}), {15'd0, 1'b1, 16'h0304});
        bus.ramRData = 16'hA5A5;
        tick();
        check("r_c5_valid",   32'({bus.memValid, bus.memRData}), {15'd0, 1'b1, 16'hA5A5});
        bus.exMemMemRead = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the single-ported unified RAM between the instruction-fetch stage and the data-memory stage of the five-stage pipeline. Data accesses have priority over fetches. The block sequences each RAM transaction through a ready handshake. It also drives the pipeline freeze signals (`pcWrite`, `ifIdWrite`, `memStall`) that sit alongside the hazard-detection stalls.

## Interface
Parameters:
- `ADDR_W`, 16: RAM address width.
- `DATA_W`, 16: RAM data width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `resetN`  in  1  synchronous, active-low reset.
- `ifReq`  in  1  fetch stage requests an instruction; held until `ifValid`.
- `ifAddr`  in  ADDR_W  fetch address (PC).
- `ifFlush`  in  1  branch taken; discard any in-flight fetch.
- `ifData`  out  DATA_W  fetched instruction; valid while `ifValid`=1.
- `ifValid`  out  1  one-cycle completion pulse for fetch.
- `exMemMemRead`  in  1  MEM-stage load request; held until `memValid`.
- `exMemMemWrite`  in  1  MEM-stage store request; held until `memValid`.
- `memAddr`  in  ADDR_W  data address.
- `memWData`  in  DATA_W  store data.
- `memRData`  out  DATA_W  load result; valid while `memValid`=1.
- `memValid`  out  1  one-cycle completion pulse for a load or a store.
- `ramEn`, `ramWe`  out  1  RAM strobe and write enable.
- `ramAddr`  out  ADDR_W  RAM address.
- `ramWData`  out  DATA_W  RAM write data.
- `ramRData`  in  DATA_W  RAM read data; sampled when `ramReady`=1.
- `ramReady`  in  1  RAM completion; may be high in the first wait cycle.
- `pcWrite`, `ifIdWrite`  out  1  0 = hold PC and IF/ID register.
- `memStall`  out  1  1 = freeze the whole pipeline (ID/EX, EX/MEM, MEM/WB).

## Operation
States:
- `IDLE`: no RAM transaction in flight.
- `FETCH_WAIT`: fetch transaction in flight.
- `DATA_WAIT`: load or store transaction in flight.

`IDLE` behaviour:
- An asserted request wins in this priority order: data (`exMemMemRead` or `exMemMemWrite`), then fetch.
- The winning request registers `ramEn`=1, `ramAddr`, `ramWe` (1 only for a store) and `ramWData`, then moves to the matching WAIT state.
- A request is ignored in the cycle its own valid pulse is high. That cycle is the pipeline-advance cycle, and the request line is still showing the completed access.
- `ramReady` is ignored in `IDLE`.

WAIT-state behaviour:
- RAM outputs are held stable until `ramReady` is sampled high.
- On that edge the block registers the result into `ifData` or `memRData`, pulses the matching valid, clears `ramEn`/`ramWe`, and returns to `IDLE`.
- Transactions are never preempted; a data request arriving during `FETCH_WAIT` waits for the fetch to complete.

Flush:
- `ifFlush` high in `FETCH_WAIT`, or in the cycle `ramReady` completes a fetch, sets a discard flag.
- The fetch still completes on the RAM side, but `ifValid` stays 0 and `ifData` is unchanged.
- The flag clears on return to `IDLE`.

Stall outputs (combinational from state, requests and valids):
- `memStall` = (`exMemMemRead` | `exMemMemWrite`) & ~`memValid`.
- `pcWrite` = `ifIdWrite` = ~`memStall` & ~(`ifReq` & ~`ifValid`).

Store and load asserted together is illegal; the block treats it as a store.

## Timing
- Reset values: state `IDLE`; `ramEn`, `ramWe`, `ifValid`, `memValid`, discard flag all 0; `ramAddr`, `ramWData`, `ifData`, `memRData` all 0. The stall outputs then follow the input requests.
- Reset mid-transaction: return to `IDLE` and drop the in-flight result. No valid pulse is produced, and a later `ramReady` is ignored.
- Minimum latency is 2 cycles from request to valid:
  - Request sampled at edge k.
  - `ramEn` high after edge k.
  - `ramReady` sampled high at edge k+1.
  - Valid high during cycle k+1..k+2.
- Each wait state the RAM adds extends the latency by one cycle.
- Back-to-back transactions always have one `IDLE` cycle between them (the valid cycle).
- Both requests present in `IDLE`: data is served first. The fetch is issued in the `IDLE` cycle after `memValid`, so the fetch valid arrives no earlier than 4 cycles after the original request.
- The valid pulse lasts exactly one cycle; `ifData` and `memRData` hold their value until the next completion.

## Structure
- Shared package `memory_arbiter_pkg` holds:
  - state encoding constants: `IDLE`=2'b00, `FETCH_WAIT`=2'b01, `DATA_WAIT`=2'b10 (2'b11 recovers to `IDLE`);
  - default `ADDR_W`/`DATA_W` constants shared with the RAM model.
- Single flat module; no sub-module is natural.

## Test plan
- Single fetch: `ifReq`=1, `ifAddr`=16'h0004, RAM ready with 0 wait -> `ramEn` high for 1 cycle with `ramAddr`=16'h0004; `ifValid` at cycle 2 with `ifData`=`ramRData`; `pcWrite`=0 in cycles 0–1 and 1 in cycle 2.
- Simultaneous requests: `ifReq` and `exMemMemRead`, `memAddr`=16'h0100 -> data served first (`memValid` at cycle 2), fetch `ifValid` at cycle 4; `memStall`=1 in cycles 0–1.
- Store with 3 wait states: `exMemMemWrite`, `memWData`=16'hBEEF -> `ramWe`=1 held 4 cycles with stable address and data; `memValid` at cycle 5; `memRData` unchanged.
- Flush in flight: `ifFlush` pulsed in `FETCH_WAIT` -> no `ifValid`, `ifData` unchanged; the next `ifReq` is served normally.
- Reset mid-transaction: `resetN`=0 during `DATA_WAIT`, then `ramReady`=1 after release -> no `memValid`; all outputs at reset values; next request has normal 2-cycle latency.
